// File: rtl/iter_engine_rr_sched.sv
// Round-robin owner arbitration for one shared iteration engine: grants a single
// requester, holds the engine enabled until done or watchdog abort, then rotates.
module iter_engine_rr_sched #(
  parameter int unsigned NUM_REQ        = 4,
  parameter int unsigned IDX_W          = 2,
  parameter int unsigned TIMEOUT_CYCLES = 4096,
  parameter int unsigned TMO_W          = 13
) (
  input  logic               clock,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] in_req,
  input  logic               in_allItersDoneFlag,
  output logic               op_enableEntireModule,
  output logic [NUM_REQ-1:0] op_grant,
  output logic [IDX_W-1:0]   op_grantIdx,
  output logic               op_busy,
  output logic [NUM_REQ-1:0] op_doneToReq,
  output logic               op_timeoutErr
);

  localparam logic [IDX_W-1:0] PTR_RST  = IDX_W'(NUM_REQ - 1);
  localparam logic             TMO_EN   = (TIMEOUT_CYCLES != 0);
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t             r_state;
  logic [IDX_W-1:0]   r_ptr;
  logic [TMO_W-1:0]   r_wdog;
  logic [NUM_REQ-1:0] r_grant;
  logic [IDX_W-1:0]   r_idx;
  logic               r_busy;
  logic               r_en;
  logic [NUM_REQ-1:0] r_done;
  logic               r_tmo;

  state_t             w_state_nxt;
  logic [IDX_W-1:0]   w_ptr_nxt;
  logic [TMO_W-1:0]   w_wdog_nxt;
  logic [NUM_REQ-1:0] w_grant_nxt;
  logic [IDX_W-1:0]   w_idx_nxt;
  logic               w_busy_nxt;
  logic               w_en_nxt;
  logic [NUM_REQ-1:0] w_done_nxt;
  logic               w_tmo_nxt;

  logic               w_any;
  logic [IDX_W-1:0]   w_win;

  // Winner search: walk downward so the lowest offset from ptr+1 is the last write.
  always_comb begin
    int unsigned      cand;
    logic [IDX_W-1:0] ci;
    w_any = |in_req;
    w_win = '0;
    cand  = 0;
    ci    = '0;
    for (int i = int'(NUM_REQ); i >= 1; i--) begin
      cand = 32'(r_ptr) + 32'(i);
      if (cand >= NUM_REQ) cand = cand - NUM_REQ;
      ci = IDX_W'(cand);
      if (in_req[ci]) w_win = ci;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_wdog_nxt  = r_wdog;
    w_grant_nxt = r_grant;
    w_idx_nxt   = r_idx;
    w_busy_nxt  = r_busy;
    w_en_nxt    = r_en;
    w_done_nxt  = '0;
    w_tmo_nxt   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_any) begin
          w_grant_nxt = NUM_REQ'(1) << w_win;
          w_idx_nxt   = w_win;
          w_busy_nxt  = 1'b1;
          w_en_nxt    = 1'b1;
          w_wdog_nxt  = '0;
          w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        if (r_wdog != '1) w_wdog_nxt = r_wdog + TMO_W'(1);
        // Completion outranks a coincident watchdog expiry.
        if (in_allItersDoneFlag) begin
          w_grant_nxt = '0;
          w_busy_nxt  = 1'b0;
          w_en_nxt    = 1'b0;
          w_done_nxt  = r_grant;
          w_ptr_nxt   = r_idx;
          w_state_nxt = ST_GAP;
        end else if (TMO_EN && (r_wdog == TMO_LAST)) begin
          w_grant_nxt = '0;
          w_busy_nxt  = 1'b0;
          w_en_nxt    = 1'b0;
          w_tmo_nxt   = 1'b1;
          w_ptr_nxt   = r_idx;
          w_state_nxt = ST_GAP;
        end
      end
      ST_GAP: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_grant_nxt = '0;
        w_busy_nxt  = 1'b0;
        w_en_nxt    = 1'b0;
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_ptr   <= PTR_RST;
      r_wdog  <= '0;
      r_grant <= '0;
      r_idx   <= '0;
      r_busy  <= 1'b0;
      r_en    <= 1'b0;
      r_done  <= '0;
      r_tmo   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_wdog  <= w_wdog_nxt;
      r_grant <= w_grant_nxt;
      r_idx   <= w_idx_nxt;
      r_busy  <= w_busy_nxt;
      r_en    <= w_en_nxt;
      r_done  <= w_done_nxt;
      r_tmo   <= w_tmo_nxt;
    end
  end

  assign op_enableEntireModule = r_en;
  assign op_grant              = r_grant;
  assign op_grantIdx           = r_idx;
  assign op_busy               = r_busy;
  assign op_doneToReq          = r_done;
  assign op_timeoutErr         = r_tmo;

endmodule

// File: tb/tb_iter_engine_rr_sched.sv
// Scoreboard bench for iter_engine_rr_sched: the driver queues timed grant/done/timeout
// events, a negedge monitor matches what the DUT actually presents.
module tb_iter_engine_rr_sched;

  localparam int unsigned NR  = 4;
  localparam int unsigned IW  = 2;
  localparam int unsigned TMO = 16;
  localparam int unsigned TW  = 5;

  localparam int K_GRANT = 0;
  localparam int K_DONE  = 1;
  localparam int K_TMO   = 2;

  logic          clock = 1'b0;
  logic          reset;
  logic [NR-1:0] in_req;
  logic          done_flag;
  logic          en;
  logic [NR-1:0] grant;
  logic [IW-1:0] gidx;
  logic          busy;
  logic [NR-1:0] done_to_req;
  logic          tmo_err;

  iter_engine_rr_sched #(
    .NUM_REQ(NR), .IDX_W(IW), .TIMEOUT_CYCLES(TMO), .TMO_W(TW)
  ) dut (
    .clock                 (clock),
    .reset                 (reset),
    .in_req                (in_req),
    .in_allItersDoneFlag   (done_flag),
    .op_enableEntireModule (en),
    .op_grant              (grant),
    .op_grantIdx           (gidx),
    .op_busy               (busy),
    .op_doneToReq          (done_to_req),
    .op_timeoutErr         (tmo_err)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  always @(posedge clock) cyc <= cyc + 1;

  typedef struct {
    int         kind;
    logic [3:0] val;
    int         at;
  } ev_t;

  ev_t q[$];

  task automatic expect_ev(input int kind, input logic [3:0] val, input int at);
    ev_t e;
    e.kind = kind;
    e.val  = val;
    e.at   = at;
    q.push_back(e);
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clock);
    #1;
  endtask

  task automatic tick_to(input int t);
    while (cyc < t) tick(1);
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h cyc=%0d", name, act, exp, cyc);
    end
  endtask

  task automatic check_zero(input string name);
    check(name, 32'({en, grant, gidx, busy, done_to_req, tmo_err}), 32'd0);
  endtask

  // Monitor: structural invariants every cycle, then event matching against the queue.
  logic prev_busy = 1'b0;
  always @(negedge clock) begin
    ev_t        e;
    int         k;
    logic [3:0] v;
    logic       seen;
    logic       inv_ok;
    inv_ok = ((grant & (grant - 4'd1)) == 4'd0) && (en == busy) && (busy == (|grant)) &&
             (!busy || (grant == (4'd1 << gidx))) && !((|done_to_req) && tmo_err);
    total++;
    if (inv_ok !== 1'b1) begin
      bad++;
      $display("FAIL invariant cyc=%0d actual en=%b busy=%b grant=%b idx=%0d done=%b tmo=%b",
               cyc, en, busy, grant, gidx, done_to_req, tmo_err);
    end
    seen = 1'b0;
    k    = 0;
    v    = 4'd0;
    if (busy && !prev_busy) begin
      k = K_GRANT; v = grant; seen = 1'b1;
    end else if (|done_to_req) begin
      k = K_DONE; v = done_to_req; seen = 1'b1;
    end else if (tmo_err) begin
      k = K_TMO; v = 4'd0; seen = 1'b1;
    end
    if (seen) begin
      total++;
      if (q.size() == 0) begin
        bad++;
        $display("FAIL unexpected_event kind=%0d val=%b cyc=%0d required=none", k, v, cyc);
      end else begin
        e = q.pop_front();
        if (e.kind != k || e.val != v || e.at != cyc) begin
          bad++;
          $display("FAIL event actual kind=%0d val=%b cyc=%0d required kind=%0d val=%b cyc=%0d",
                   k, v, cyc, e.kind, e.val, e.at);
        end
      end
    end
    while (q.size() > 0 && q[0].at < cyc) begin
      e = q.pop_front();
      total++;
      bad++;
      $display("FAIL missing_event actual=none required kind=%0d val=%b cyc=%0d",
               e.kind, e.val, e.at);
    end
    prev_busy = busy;
  end

  initial begin
    int         c;
    int         g;
    logic [3:0] oh;
    reset     = 1'b1;
    in_req    = 4'd0;
    done_flag = 1'b0;
    tick(2);
    check_zero("reset_outputs");
    reset = 1'b0;

    // 1: single requester, done after 10 RUN cycles
    tick(1);
    c = cyc;
    in_req = 4'b0100;
    expect_ev(K_GRANT, 4'b0100, c + 1);
    tick_to(c + 10);
    check("t1_en_10th_cycle", 32'(en), 32'd1);
    check("t1_idx", 32'(gidx), 32'd2);
    done_flag = 1'b1;
    expect_ev(K_DONE, 4'b0100, c + 11);
    tick(1);
    done_flag = 1'b0;
    in_req = 4'd0;
    check("t1_en_after_done", 32'(en), 32'd0);
    tick(1);
    check("t1_gap_busy", 32'(busy), 32'd0);
    tick(3);

    // 2: all requesting, rotation 0,1,2,3,0 with 2-cycle re-grant
    reset = 1'b1;
    tick(2);
    reset = 1'b0;
    c = cyc;
    in_req = 4'b1111;
    g = c + 1;
    expect_ev(K_GRANT, 4'b0001, g);
    for (int k = 0; k < 5; k++) begin
      tick_to(g + 2);
      done_flag = 1'b1;
      oh = 4'b0001 << (k % 4);
      expect_ev(K_DONE, oh, g + 3);
      if (k < 4) begin
        oh = 4'b0001 << ((k + 1) % 4);
        expect_ev(K_GRANT, oh, g + 5);
      end
      tick(1);
      done_flag = 1'b0;
      if (k == 4) in_req = 4'd0;
      g = g + 5;
    end
    tick(4);

    // 3: done flag in IDLE and in GAP is ignored
    done_flag = 1'b1;
    tick(2);
    done_flag = 1'b0;
    tick(1);
    check("t3_idle_busy", 32'(busy), 32'd0);
    c = cyc;
    in_req = 4'b0001;
    g = c + 1;
    expect_ev(K_GRANT, 4'b0001, g);
    tick_to(g + 2);
    done_flag = 1'b1;
    expect_ev(K_DONE, 4'b0001, g + 3);
    tick(1);
    in_req = 4'd0;
    tick(1);
    done_flag = 1'b0;
    check("t3_gap_done", 32'(done_to_req), 32'd0);
    tick(3);

    // 4: watchdog abort after 16 RUN cycles, pointer moves to owner 0
    c = cyc;
    in_req = 4'b0001;
    g = c + 1;
    expect_ev(K_GRANT, 4'b0001, g);
    expect_ev(K_TMO, 4'd0, g + 16);
    tick_to(g + 15);
    check("t4_en_before_tmo", 32'(en), 32'd1);
    tick(1);
    check("t4_grant_after_tmo", 32'(grant), 32'd0);
    check("t4_no_done", 32'(done_to_req), 32'd0);
    in_req = 4'd0;
    tick(1);
    in_req = 4'b0011;
    g = g + 18;
    expect_ev(K_GRANT, 4'b0010, g);
    tick_to(g + 2);
    done_flag = 1'b1;
    expect_ev(K_DONE, 4'b0010, g + 3);
    tick(1);
    done_flag = 1'b0;
    in_req = 4'd0;
    tick(3);

    // 5: done coincident with watchdog expiry -> done wins
    c = cyc;
    in_req = 4'b0100;
    g = c + 1;
    expect_ev(K_GRANT, 4'b0100, g);
    tick_to(g + 15);
    done_flag = 1'b1;
    expect_ev(K_DONE, 4'b0100, g + 16);
    tick(1);
    done_flag = 1'b0;
    in_req = 4'd0;
    check("t5_tmo_low", 32'(tmo_err), 32'd0);
    tick(3);

    // 6: reset mid-RUN, then pointer restarts so req 0 wins
    c = cyc;
    in_req = 4'b0010;
    g = c + 1;
    expect_ev(K_GRANT, 4'b0010, g);
    tick_to(g + 3);
    reset = 1'b1;
    tick(1);
    check_zero("t6_reset_mid_run");
    reset = 1'b0;
    in_req = 4'b0011;
    c = cyc;
    expect_ev(K_GRANT, 4'b0001, c + 1);
    tick_to(c + 3);
    done_flag = 1'b1;
    expect_ev(K_DONE, 4'b0001, c + 4);
    tick(1);
    done_flag = 1'b0;
    in_req = 4'd0;
    tick(4);

    total++;
    if (q.size() != 0) begin
      bad++;
      $display("FAIL queue_drained actual=%0d required=0", q.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
